// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line idle level and
// parameter legality helpers used by elaboration-time checks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  localparam logic UART_LINE_IDLE = 1'b1;

  function automatic bit uart_data_bits_legal(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; both flops
// take RESET_VAL under the synchronous active-low reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority-vote sampling, false-start
// rejection and valid/ready output. Parity is compiled in with UART_RX_PARITY_EN.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_x,
  input  logic                 data_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] S0   = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] S1   = CW'(OVERSAMPLE/2);
  localparam logic [CW-1:0] S2   = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] WRAP = CW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_e AFTER_DATA = PARITY;
  localparam logic ODD = 1'(PARITY_ODD);
`else
  localparam uart_rx_state_e AFTER_DATA = STOP;
`endif

  if (!uart_data_bits_legal(DATA_BITS)) begin : g_bad_data_bits
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if ((OVERSAMPLE < 4) || (OVERSAMPLE % 2 != 0)) begin : g_bad_oversample
    $error("uart_rx_os: OVERSAMPLE must be even and >= 4");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity_odd
    $error("uart_rx_os: PARITY_ODD must be 0 or 1");
  end

  logic rx;

  uart_sync2 #(.RESET_VAL(UART_LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (data_in),
    .q_o (rx)
  );

  uart_rx_state_e       state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 armed_q, armed_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] sreg_q, sreg_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_out_q, perr_out_q, ovr_q;
  logic                 maj, decide, wrap, last_stop, done;

  assign maj       = (s0_q & s1_q) | (s0_q & rx) | (s1_q & rx);
  assign decide    = baud_x && (cnt_q == S2);
  assign wrap      = baud_x && (cnt_q == WRAP);
  assign last_stop = (STOP_BITS == 1) || stop_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    stop_d  = stop_q;
    armed_d = armed_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    sreg_d  = sreg_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    done    = 1'b0;
    if (baud_x) begin
      if (state_q != IDLE) begin
        cnt_d = (cnt_q == WRAP) ? '0 : cnt_q + CW'(1);
        if (cnt_q == S0) s0_d = rx;
        if (cnt_q == S1) s1_d = rx;
      end
      case (state_q)
        IDLE: begin
          if (rx) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d = START;
            cnt_d   = '0;
            armed_d = 1'b0;
            stop_d  = 1'b0;
            ferr_d  = 1'b0;
            perr_d  = 1'b0;
          end
        end
        START: begin
          if (decide && maj) state_d = IDLE;
          else if (wrap) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
        DATA: begin
          if (decide) sreg_d[idx_q] = maj;
          if (wrap) begin
            if (idx_q == LAST_IDX) state_d = AFTER_DATA;
            else                   idx_d   = idx_q + IW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (decide) perr_d = maj ^ (^sreg_q) ^ ODD;
          if (wrap)   state_d = STOP;
        end
`endif
        STOP: begin
          if (decide) begin
            ferr_d = ferr_q | ~maj;
            if (last_stop) begin
              // Leave at the decision point; a low stop bit (break) keeps armed clear.
              done    = 1'b1;
              state_d = IDLE;
              armed_d = maj;
            end else begin
              stop_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      armed_q    <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      sreg_q     <= '0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_out_q <= 1'b0;
      perr_out_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      stop_q  <= stop_d;
      armed_q <= armed_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      sreg_q  <= sreg_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      ovr_q   <= done && valid_q && !ready;
      if (done) begin
        data_q     <= sreg_q;
        ferr_out_q <= ferr_d;
        perr_out_q <= perr_q;
        valid_q    <= 1'b1;
      end else if (ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_out_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_out_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: an 8N1 instance and a 7-bit, 2-stop instance.
module tb_uart_rx_os;

  localparam int OS  = 16;
  localparam int DBA = 8;
  localparam int DBB = 7;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct packed {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic baud_x = 1'b0;
  logic rst_a, rst_b, din_a, din_b, rdy_a, rdy_b;
  logic [DBA-1:0] dout_a;
  logic [DBB-1:0] dout_b;
  logic val_a, fe_a, pe_a, ov_a;
  logic val_b, fe_b, pe_b, ov_b;

  int total = 0;
  int bad   = 0;
  exp_t qa[$];
  exp_t qb[$];
  int acc_a = 0, acc_b = 0, ovr_a = 0, vh_a = 0;
  int unsigned div = 0;

  uart_rx_os #(.DATA_BITS(DBA), .OVERSAMPLE(OS), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst(rst_a), .baud_x(baud_x), .data_in(din_a),
    .data_out(dout_a), .valid(val_a), .ready(rdy_a),
    .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
  );

  uart_rx_os #(.DATA_BITS(DBB), .OVERSAMPLE(OS), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst(rst_b), .baud_x(baud_x), .data_in(din_b),
    .data_out(dout_b), .valid(val_b), .ready(rdy_b),
    .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
  );

  always #5 clk = ~clk;

  // One baud_x pulse every third clock, changed away from the rising edge.
  always @(negedge clk) begin
    div    = (div == 2) ? 0 : div + 1;
    baud_x = (div == 0);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!baud_x) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) din_b = v;
    else     din_a = v;
  endtask

  task automatic send(input bit sel, input logic [8:0] d, input bit flip, input bit st0, input bit st1);
    int nb;
    int ns;
    logic [8:0] m;
    exp_t e;
    nb = sel ? DBB : DBA;
    ns = sel ? 2 : 1;
    m = d & ((9'd1 << nb) - 9'd1);
    e.data = m;
    e.fe   = !st0 || ((ns == 2) && !st1);
    e.pe   = PAR_EN & flip;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
    drive(sel, 1'b0);
    ticks(OS);
    for (int i = 0; i < nb; i++) begin
      drive(sel, m[i]);
      ticks(OS);
    end
    if (PAR_EN) begin
      drive(sel, (^m) ^ flip);
      ticks(OS);
    end
    drive(sel, st0);
    ticks(OS);
    if (ns == 2) begin
      drive(sel, st1);
      ticks(OS);
    end
    drive(sel, 1'b1);
  endtask

  always @(negedge clk) begin
    if (val_a) vh_a++;
    if (ov_a) begin
      ovr_a++;
      if (qa.size() > 0) qa.delete(0);
    end
    if (val_a && rdy_a) begin
      acc_a++;
      if (qa.size() == 0) chk("a_unexpected", 1, 0);
      else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_data", 32'(dout_a), 32'(e.data));
        chk("a_frame_err", 32'(fe_a), 32'(e.fe));
        chk("a_parity_err", 32'(pe_a), 32'(e.pe));
      end
    end
  end

  always @(negedge clk) begin
    if (ov_b && qb.size() > 0) qb.delete(0);
    if (val_b && rdy_b) begin
      acc_b++;
      if (qb.size() == 0) chk("b_unexpected", 1, 0);
      else begin
        exp_t e;
        e = qb.pop_front();
        chk("b_data", 32'(dout_b), 32'(e.data));
        chk("b_frame_err", 32'(fe_b), 32'(e.fe));
        chk("b_parity_err", 32'(pe_b), 32'(e.pe));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int n0;
    int o0;
    rst_a = 1'b0; rst_b = 1'b0;
    din_a = 1'b1; din_b = 1'b1;
    rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_valid", 32'(val_a), 0);
    chk("rst_data", 32'(dout_a), 0);
    chk("rst_flags", 32'({fe_a, pe_a, ov_a}), 0);
    rst_a = 1'b1; rst_b = 1'b1;
    ticks(2 * OS);

    v0 = vh_a;
    send(1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1);
    ticks(OS);
    chk("a5_valid_width", 32'(vh_a - v0), 1);
    chk("a5_accepted", 32'(acc_a), 1);

    din_a = 1'b0;
    ticks(4);
    din_a = 1'b1;
    ticks(2 * OS);
    chk("glitch_no_frame", 32'(acc_a), 1);
    send(1'b0, 9'h03C, 1'b0, 1'b1, 1'b1);
    ticks(OS);
    chk("3c_accepted", 32'(acc_a), 2);

`ifdef UART_RX_PARITY_EN
    send(1'b0, 9'h03C, 1'b1, 1'b1, 1'b1);
    ticks(OS);
    send(1'b0, 9'h03C, 1'b0, 1'b1, 1'b1);
    ticks(OS);
`endif

    n0 = acc_a;
    send(1'b0, 9'h081, 1'b0, 1'b0, 1'b1);
    din_a = 1'b0;
    ticks(3 * OS);
    chk("break_one_frame", 32'(acc_a - n0), 1);
    din_a = 1'b1;
    ticks(2 * OS);
    chk("break_no_second", 32'(acc_a - n0), 1);

    rdy_a = 1'b0;
    o0 = ovr_a;
    send(1'b0, 9'h011, 1'b0, 1'b1, 1'b1);
    send(1'b0, 9'h022, 1'b0, 1'b1, 1'b1);
    ticks(OS);
    chk("ovr_pulse_once", 32'(ovr_a - o0), 1);
    chk("ovr_valid_held", 32'(val_a), 1);
    chk("ovr_data", 32'(dout_a), 32'h22);
    @(posedge clk);
    #1 rdy_a = 1'b1;
    @(posedge clk);
    #1 chk("ready_drops_valid", 32'(val_a), 0);

    rdy_b = 1'b0;
    send(1'b1, 9'h02A, 1'b0, 1'b1, 1'b1);
    ticks(OS);
    chk("b_pending_valid", 32'(val_b), 1);
    din_b = 1'b0; ticks(OS);
    din_b = 1'b1; ticks(OS);
    din_b = 1'b0; ticks(OS);
    din_b = 1'b1; ticks(OS);
    rst_b = 1'b0;
    qb.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("b_rst_valid", 32'(val_b), 0);
    chk("b_rst_data", 32'(dout_b), 0);
    chk("b_rst_flags", 32'({fe_b, pe_b, ov_b}), 0);
    rst_b = 1'b1;
    rdy_b = 1'b1;
    ticks(2 * OS);
    send(1'b1, 9'h055, 1'b0, 1'b1, 1'b1);
    ticks(OS);
    send(1'b1, 9'h02B, 1'b0, 1'b1, 1'b0);
    ticks(2 * OS);
    chk("b_accepted", 32'(acc_b), 2);

    chk("qa_drained", 32'(qa.size()), 0);
    chk("qb_drained", 32'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
